// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the execute-stage divider: operand width, M-extension
// divide op encodings and the divider FSM state type.
package rv32_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [1:0] DIV_OP_DIV  = 2'b00;
   localparam logic [1:0] DIV_OP_DIVU = 2'b01;
   localparam logic [1:0] DIV_OP_REM  = 2'b10;
   localparam logic [1:0] DIV_OP_REMU = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FINISH
   } div_state_t;

endpackage

// File: rtl/div_unit.sv
// Iterative restoring RV32M divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Define DIV_EARLY_OUT_EN to skip CALC for trivial requests.
module div_unit #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clock_i,
   input  logic            reset_i,
   input  logic            start_i,
   input  logic [1:0]      op_i,
   input  logic [4:0]      rd_i,
   input  logic [XLEN-1:0] rs1_data_i,
   input  logic [XLEN-1:0] rs2_data_i,
   output logic            busy_o,
   output logic            done_o,
   output logic            reg_write_o,
   output logic [4:0]      wr_register_o,
   output logic [XLEN-1:0] wr_data_o
);
   import rv32_pkg::*;

   localparam int unsigned CntW = $clog2(XLEN);

   div_state_t state_q, state_d;

   logic [CntW-1:0] cnt_q;
   logic [1:0]      op_q;
   logic [4:0]      rd_q;
   logic            quot_neg_q, rem_neg_q, div_zero_q, ovf_q;
   logic [XLEN-1:0] dividend_q, divisor_q, quot_q;
   logic [XLEN:0]   rem_q;

   logic            done_q, reg_write_q;
   logic [4:0]      wr_register_q;
   logic [XLEN-1:0] wr_data_q;

   // Request decode, used only in the start cycle.
   logic            is_signed, a_neg, b_neg, b_zero, ovf, early;
   logic [XLEN-1:0] a_mag, b_mag;

   always_comb begin
      is_signed = (op_i == DIV_OP_DIV) || (op_i == DIV_OP_REM);
      a_neg     = is_signed & rs1_data_i[XLEN-1];
      b_neg     = is_signed & rs2_data_i[XLEN-1];
      a_mag     = a_neg ? -rs1_data_i : rs1_data_i;
      b_mag     = b_neg ? -rs2_data_i : rs2_data_i;
      b_zero    = (rs2_data_i == '0);
      ovf       = is_signed && (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data_i == '1);
`ifdef DIV_EARLY_OUT_EN
      early     = b_zero || ovf || (b_mag > a_mag);
`else
      early     = 1'b0;
`endif
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_i) state_d = early ? FINISH : CALC;
         CALC:    if (cnt_q == '0) state_d = FINISH;
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // One restoring step: shift {rem, quot} left and trial-subtract the divisor.
   logic [XLEN:0]   rem_sh;
   logic [XLEN-1:0] quot_sh;
   logic [XLEN+1:0] diff;

   always_comb begin
      rem_sh  = {rem_q[XLEN-1:0], quot_q[XLEN-1]};
      quot_sh = {quot_q[XLEN-2:0], 1'b0};
      diff    = {1'b0, rem_sh} - {2'b00, divisor_q};
   end

   // Sign fix and forced RISC-V results for the special cases.
   logic [XLEN-1:0] quot_fix, rem_fix, result;

   always_comb begin
      quot_fix = quot_neg_q ? -quot_q : quot_q;
      rem_fix  = rem_neg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
      if (div_zero_q) begin
         quot_fix = '1;
         rem_fix  = dividend_q;
      end else if (ovf_q) begin
         quot_fix = {1'b1, {(XLEN-1){1'b0}}};
         rem_fix  = '0;
      end
      result = ((op_q == DIV_OP_REM) || (op_q == DIV_OP_REMU)) ? rem_fix : quot_fix;
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         cnt_q         <= '0;
         op_q          <= '0;
         rd_q          <= '0;
         quot_neg_q    <= 1'b0;
         rem_neg_q     <= 1'b0;
         div_zero_q    <= 1'b0;
         ovf_q         <= 1'b0;
         dividend_q    <= '0;
         divisor_q     <= '0;
         quot_q        <= '0;
         rem_q         <= '0;
         done_q        <= 1'b0;
         reg_write_q   <= 1'b0;
         wr_register_q <= '0;
         wr_data_q     <= '0;
      end else begin
         done_q      <= 1'b0;
         reg_write_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  op_q       <= op_i;
                  rd_q       <= rd_i;
                  quot_neg_q <= a_neg ^ b_neg;
                  rem_neg_q  <= a_neg;
                  div_zero_q <= b_zero;
                  ovf_q      <= ovf;
                  dividend_q <= rs1_data_i;
                  divisor_q  <= b_mag;
                  cnt_q      <= CntW'(XLEN - 1);
                  // Early-out leaves quotient 0 and remainder |dividend| ready for FINISH.
                  if (early) begin
                     rem_q  <= {1'b0, a_mag};
                     quot_q <= '0;
                  end else begin
                     rem_q  <= '0;
                     quot_q <= a_mag;
                  end
               end
            end
            CALC: begin
               cnt_q <= cnt_q - 1'b1;
               if (!diff[XLEN+1]) begin
                  rem_q  <= diff[XLEN:0];
                  quot_q <= quot_sh | {{(XLEN-1){1'b0}}, 1'b1};
               end else begin
                  rem_q  <= rem_sh;
                  quot_q <= quot_sh;
               end
            end
            FINISH: begin
               done_q        <= 1'b1;
               reg_write_q   <= (rd_q != '0);
               wr_register_q <= rd_q;
               wr_data_q     <= result;
            end
            default: ;
         endcase
      end
   end

   assign busy_o        = (state_q != IDLE);
   assign done_o        = done_q;
   assign reg_write_o   = reg_write_q;
   assign wr_register_o = wr_register_q;
   assign wr_data_o     = wr_data_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed RV32M cases, busy/reset handling, then random
// back-to-back requests checked against an arithmetic reference model.
module tb_div_unit;
   import rv32_pkg::*;

   logic        clock_i = 1'b0;
   logic        reset_i, start_i;
   logic [1:0]  op_i;
   logic [4:0]  rd_i;
   logic [31:0] rs1_data_i, rs2_data_i;
   logic        busy_o, done_o, reg_write_o;
   logic [4:0]  wr_register_o;
   logic [31:0] wr_data_o;

   div_unit #(.XLEN(XLEN)) dut (
      .clock_i       (clock_i),
      .reset_i       (reset_i),
      .start_i       (start_i),
      .op_i          (op_i),
      .rd_i          (rd_i),
      .rs1_data_i    (rs1_data_i),
      .rs2_data_i    (rs2_data_i),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .reg_write_o   (reg_write_o),
      .wr_register_o (wr_register_o),
      .wr_data_o     (wr_data_o)
   );

   always #5 clock_i = ~clock_i;

   typedef struct {
      logic [31:0] data;
      logic [4:0]  rd;
      logic        we;
      int          cyc;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   always @(posedge clock_i) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      logic signed [31:0] sa_v, sb_v;
      sa_v = a;
      sb_v = b;
      case (op)
         DIV_OP_DIV: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return sa_v / sb_v;
         end
         DIV_OP_REM: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return sa_v % sb_v;
         end
         DIV_OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         default:     return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
      logic        sgn;
      logic [31:0] ma, mb;
      sgn = (op == DIV_OP_DIV) || (op == DIV_OP_REM);
      ma  = (sgn && a[31]) ? 32'(-a) : a;
      mb  = (sgn && b[31]) ? 32'(-b) : b;
      if (b == 0) return 2;
      if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
      if (mb > ma) return 2;
`endif
      return 34;
   endfunction

   function automatic logic [31:0] rnd_val();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   // Called at a negedge; waits for IDLE, drives one start cycle, returns at next negedge.
   task automatic issue(input logic [1:0] op, input logic [4:0] rd, input logic [31:0] a,
                        input logic [31:0] b, input bit push, input bit use_exp,
                        input logic [31:0] exp_v);
      int   n = 0;
      exp_t e;
      while (busy_o && n < 200) begin
         @(negedge clock_i);
         n++;
      end
      if (busy_o) check("issue_wait_timeout", {31'b0, busy_o}, 32'h0);
      start_i    = 1'b1;
      op_i       = op;
      rd_i       = rd;
      rs1_data_i = a;
      rs2_data_i = b;
      if (push) begin
         e.data = use_exp ? exp_v : ref_result(op, a, b);
         e.rd   = rd;
         e.we   = (rd != 0);
         e.cyc  = cyc + ref_latency(op, a, b);
         sb_q.push_back(e);
      end
      @(negedge clock_i);
      start_i    = 1'b0;
      op_i       = 2'($urandom);
      rd_i       = 5'($urandom);
      rs1_data_i = $urandom;
      rs2_data_i = $urandom;
   endtask

   always @(negedge clock_i) begin
      if (!reset_i) begin
         if (done_o) begin
            if (sb_q.size() == 0) begin
               check("unexpected_done", {27'b0, wr_register_o}, 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               check("wr_data", wr_data_o, e.data);
               check("wr_register", {27'b0, wr_register_o}, {27'b0, e.rd});
               check("reg_write", {31'b0, reg_write_o}, {31'b0, e.we});
               check("done_cycle", cyc, e.cyc);
               check("busy_at_done", {31'b0, busy_o}, 32'h0);
            end
         end else if (reg_write_o) begin
            check("reg_write_without_done", {31'b0, reg_write_o}, 32'h0);
         end
      end
   end

   initial begin
      int n;
      reset_i    = 1'b1;
      start_i    = 1'b0;
      op_i       = '0;
      rd_i       = '0;
      rs1_data_i = '0;
      rs2_data_i = '0;
      repeat (3) @(negedge clock_i);
      reset_i = 1'b0;
      check("rst_busy", {31'b0, busy_o}, 32'h0);
      check("rst_done", {31'b0, done_o}, 32'h0);
      check("rst_reg_write", {31'b0, reg_write_o}, 32'h0);
      check("rst_wr_register", {27'b0, wr_register_o}, 32'h0);
      check("rst_wr_data", wr_data_o, 32'h0);

      // Busy window of a full-length request, then a back-to-back issue in cycle 34.
      issue(DIV_OP_DIVU, 5'd5, 32'd100, 32'd7, 1, 1, 32'd14);
      check("busy_cycle1", {31'b0, busy_o}, 32'h1);
      repeat (32) @(negedge clock_i);
      check("busy_cycle33", {31'b0, busy_o}, 32'h1);
      @(negedge clock_i);
      check("busy_cycle34", {31'b0, busy_o}, 32'h0);
      issue(DIV_OP_REMU, 5'd5, 32'd100, 32'd7, 1, 1, 32'd2);

      issue(DIV_OP_DIV,  5'd1, 32'hFFFF_FFF9, 32'd2,         1, 1, 32'hFFFF_FFFD);
      issue(DIV_OP_REM,  5'd2, 32'hFFFF_FFF9, 32'd2,         1, 1, 32'hFFFF_FFFF);
      issue(DIV_OP_DIV,  5'd3, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1, 1, 32'd3);
      issue(DIV_OP_DIV,  5'd4, 32'd5,         32'd0,         1, 1, 32'hFFFF_FFFF);
      issue(DIV_OP_REMU, 5'd6, 32'd5,         32'd0,         1, 1, 32'd5);
      issue(DIV_OP_DIV,  5'd7, 32'h8000_0000, 32'hFFFF_FFFF, 1, 1, 32'h8000_0000);
      issue(DIV_OP_REM,  5'd8, 32'h8000_0000, 32'hFFFF_FFFF, 1, 1, 32'h0);
      issue(DIV_OP_DIVU, 5'd0, 32'd9,         32'd3,         1, 1, 32'd3);

      // A second start at cycle 10 must be ignored.
      issue(DIV_OP_DIVU, 5'd9, 32'd1000, 32'd10, 1, 1, 32'd100);
      repeat (9) @(negedge clock_i);
      start_i    = 1'b1;
      op_i       = DIV_OP_REMU;
      rd_i       = 5'd10;
      rs1_data_i = 32'd77;
      rs2_data_i = 32'd5;
      @(negedge clock_i);
      start_i = 1'b0;

      // Reset at cycle 20 aborts the request; nothing is expected from it.
      issue(DIV_OP_DIVU, 5'd11, 32'd50, 32'd5, 0, 0, 32'h0);
      repeat (19) @(negedge clock_i);
      reset_i = 1'b1;
      @(negedge clock_i);
      reset_i = 1'b0;
      check("abort_busy_cycle21", {31'b0, busy_o}, 32'h0);
      check("abort_done_cycle21", {31'b0, done_o}, 32'h0);
      repeat (40) @(negedge clock_i);

      for (int i = 0; i < 40; i++) begin
         issue(2'($urandom), 5'($urandom), rnd_val(), rnd_val(), 1, 0, 32'h0);
      end

      n = 0;
      while (sb_q.size() != 0 && n < 200) begin
         @(negedge clock_i);
         n++;
      end
      check("scoreboard_drained", sb_q.size(), 32'h0);
      repeat (5) @(negedge clock_i);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
